icb_msp_master: RTL and testbench

- ICB initiator that drives the mel-spectrogram processor's ICB slave port.
- Streams one frame of 32-bit packed sample words from a valid/ready source into the slave's command FIFO as ICB writes.
- Then issues ICB reads to drain the packed mel results to a valid/ready sink.
- Checks every response's error flag and aborts with the slave's error code on any error.

---
 rtl/icb_msp_master.sv | 177 +++++++++++++++++
 tb/tb_icb_msp_master.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/icb_msp_master.sv
// rtl/icb_msp_master.sv - ICB initiator feeding the mel-spectrogram slave (optional watchdog: ICB_MST_TIMEOUT_EN)
module icb_msp_master #(
    parameter int          N_WR    = 80,
    parameter int          N_RD    = 10,
    parameter logic [31:0] WR_ADDR = 32'h1004_2000,
    parameter logic [31:0] RD_ADDR = 32'h1004_2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] err_code,
    input  logic        src_valid,
    output logic        src_ready,
    input  logic [31:0] src_data,
    output logic        icb_cmd_valid,
    input  logic        icb_cmd_ready,
    output logic [31:0] icb_cmd_addr,
    output logic        icb_cmd_read,
    output logic [31:0] icb_cmd_wdata,
    output logic [3:0]  icb_cmd_wmask,
    input  logic        icb_rsp_valid,
    output logic        icb_rsp_ready,
    input  logic [31:0] icb_rsp_rdata,
    input  logic        icb_rsp_err,
    output logic        dst_valid,
    input  logic        dst_ready,
    output logic [31:0] dst_data
);

    localparam int WW = $clog2(N_WR + 1);
    localparam int RW = $clog2(N_RD + 1);

    typedef enum logic [2:0] {
        IDLE, WR_CMD, WR_RSP, RD_CMD, RD_RSP, RD_OUT, ABORT, FIN
    } state_t;

    state_t        state, state_nx;
    logic [WW-1:0] wr_cnt;
    logic [RW-1:0] rd_cnt;
    logic          wdog_expired;
    logic          in_rsp;

    assign in_rsp        = (state == WR_RSP) || (state == RD_RSP);
    assign busy          = (state != IDLE) && (state != FIN);
    assign done          = (state == FIN);
    assign icb_cmd_wmask = 4'hF;

`ifdef ICB_MST_TIMEOUT_EN
    logic [15:0] wdog;

    assign wdog_expired = in_rsp && !icb_rsp_valid && (wdog == 16'hFFFF);

    // Watchdog: counts silent cycles while a response is awaited, restarts per transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog <= '0;
        end else if (!in_rsp || icb_rsp_valid) begin
            wdog <= '0;
        end else if (wdog != 16'hFFFF) begin
            wdog <= wdog + 16'd1;
        end
    end
`else
    assign wdog_expired = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and handshake outputs; the write command mirrors the source so data never needs a buffer
    always_comb begin
        state_nx      = state;
        icb_cmd_valid = 1'b0;
        icb_cmd_read  = 1'b0;
        icb_cmd_addr  = '0;
        icb_cmd_wdata = '0;
        src_ready     = 1'b0;
        icb_rsp_ready = 1'b0;
        dst_valid     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = WR_CMD;
            end
            WR_CMD: begin
                icb_cmd_valid = src_valid;
                src_ready     = icb_cmd_ready;
                icb_cmd_addr  = WR_ADDR;
                icb_cmd_wdata = src_data;
                if (src_valid && icb_cmd_ready) state_nx = WR_RSP;
            end
            WR_RSP: begin
                icb_rsp_ready = 1'b1;
                if (icb_rsp_valid) begin
                    if (icb_rsp_err)                   state_nx = ABORT;
                    else if (wr_cnt == WW'(N_WR - 1))  state_nx = RD_CMD;
                    else                               state_nx = WR_CMD;
                end else if (wdog_expired) begin
                    state_nx = ABORT;
                end
            end
            RD_CMD: begin
                icb_cmd_valid = 1'b1;
                icb_cmd_read  = 1'b1;
                icb_cmd_addr  = RD_ADDR;
                if (icb_cmd_ready) state_nx = RD_RSP;
            end
            RD_RSP: begin
                icb_rsp_ready = 1'b1;
                if (icb_rsp_valid) begin
                    state_nx = icb_rsp_err ? ABORT : RD_OUT;
                end else if (wdog_expired) begin
                    state_nx = ABORT;
                end
            end
            RD_OUT: begin
                dst_valid = 1'b1;
                if (dst_ready) state_nx = (rd_cnt == RW'(N_RD - 1)) ? FIN : RD_CMD;
            end
            ABORT:   state_nx = FIN;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Counters, captured read data and error status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            err      <= 1'b0;
            err_code <= '0;
            dst_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        wr_cnt   <= '0;
                        rd_cnt   <= '0;
                        err      <= 1'b0;
                        err_code <= '0;
                    end
                end
                WR_RSP: begin
                    if (icb_rsp_valid) begin
                        if (icb_rsp_err) err_code <= icb_rsp_rdata;
                        else             wr_cnt   <= wr_cnt + WW'(1);
                    end else if (wdog_expired) begin
                        err_code <= 32'hDEAD_0001;
                    end
                end
                RD_RSP: begin
                    if (icb_rsp_valid) begin
                        if (icb_rsp_err) err_code <= icb_rsp_rdata;
                        else             dst_data <= icb_rsp_rdata;
                    end else if (wdog_expired) begin
                        err_code <= 32'hDEAD_0001;
                    end
                end
                RD_OUT: begin
                    if (dst_ready) rd_cnt <= rd_cnt + RW'(1);
                end
                ABORT: err <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_icb_msp_master.sv
// tb/tb_icb_msp_master.sv - self-checking bench for icb_msp_master
`timescale 1ns/1ps
module tb_icb_msp_master;

    localparam int          N_WR   = 80;
    localparam int          N_RD   = 10;
    localparam logic [31:0] ADDR   = 32'h1004_2000;
    localparam int          BUDGET = 20000;

    logic        clk = 1'b0;
    logic        rst_n, start, busy, done, err;
    logic [31:0] err_code;
    logic        src_valid, src_ready;
    logic [31:0] src_data;
    logic        icb_cmd_valid, icb_cmd_ready, icb_cmd_read;
    logic [31:0] icb_cmd_addr, icb_cmd_wdata;
    logic [3:0]  icb_cmd_wmask;
    logic        icb_rsp_valid, icb_rsp_ready, icb_rsp_err;
    logic [31:0] icb_rsp_rdata;
    logic        dst_valid, dst_ready;
    logic [31:0] dst_data;

    always #5 clk = ~clk;

    icb_msp_master dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .err(err), .err_code(err_code),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
        .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
        .icb_cmd_addr(icb_cmd_addr), .icb_cmd_read(icb_cmd_read),
        .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
        .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
        .icb_rsp_rdata(icb_rsp_rdata), .icb_rsp_err(icb_rsp_err),
        .dst_valid(dst_valid), .dst_ready(dst_ready), .dst_data(dst_data)
    );

    typedef struct {
        int          stall;
        int          err_wr;
        int          err_rd;
        logic [31:0] err_val;
        logic [31:0] rd_base;
        int          src_rand;
        int          restart_at;
        int          lat;
        logic        exp_err;
        logic [31:0] exp_code;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // environment knobs and scoreboard state
    int          stall_pct = 0;
    int          err_wr_idx = -1, err_rd_idx = -1;
    logic [31:0] err_val = 0, rd_base = 0;
    bit          mute_rd0 = 0;
    logic [31:0] src_words [N_WR];
    int          src_idx = 0, wr_seen = 0, rd_seen = 0, dst_seen = 0;
    bit          pending = 0, pend_err = 0, pend_read = 0;
    int          pend_idx = 0;
    logic [31:0] pend_data = 0;
    bit          src_hs_last = 0, cmd_hs_last = 0, prev_cmd_wait = 0, prev_dst_wait = 0;
    logic [31:0] prev_addr = 0, prev_wdata = 0, prev_dst = 0;
    logic        prev_read = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic bit stall();
        return $urandom_range(0, 99) < stall_pct;
    endfunction

    task automatic step();
        @(negedge clk);
        #3;
    endtask

    // Source, ICB slave and sink models; drive at negedge, observe handshakes 1ns later
    initial begin
        src_valid = 0; src_data = 0; icb_cmd_ready = 0;
        icb_rsp_valid = 0; icb_rsp_rdata = 0; icb_rsp_err = 0; dst_ready = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                src_valid = 0; icb_cmd_ready = 0; icb_rsp_valid = 0; dst_ready = 0;
                pending = 0; src_hs_last = 0; cmd_hs_last = 0;
                prev_cmd_wait = 0; prev_dst_wait = 0;
            end else begin
                if (!(src_valid && !src_hs_last)) src_valid = (src_idx < N_WR) && !stall();
                if (src_idx < N_WR) src_data = src_words[src_idx];
                icb_cmd_ready = !stall();
                if (!pending) icb_rsp_valid = 0;
                else if (!icb_rsp_valid)
                    icb_rsp_valid = !stall() && !(mute_rd0 && pend_read && pend_idx == 0);
                icb_rsp_rdata = pend_data;
                icb_rsp_err   = pend_err;
                dst_ready = !stall();
                #1;
                src_hs_last = src_valid && src_ready;
                cmd_hs_last = icb_cmd_valid && icb_cmd_ready;
                if (icb_cmd_valid) check("rsp_ready_in_cmd", icb_rsp_ready, 0);
                if (prev_cmd_wait) begin
                    check("cmd_valid_held", icb_cmd_valid, 1);
                    check("cmd_addr_stable", icb_cmd_addr, prev_addr);
                    check("cmd_read_stable", icb_cmd_read, prev_read);
                    check("cmd_wdata_stable", icb_cmd_wdata, prev_wdata);
                end
                if (src_hs_last || (cmd_hs_last && !icb_cmd_read))
                    check("src_cmd_same_hs", src_hs_last, cmd_hs_last);
                if (cmd_hs_last) begin
                    check("one_outstanding", pending, 0);
                    check("cmd_wmask", icb_cmd_wmask, 4'hF);
                    check("cmd_addr", icb_cmd_addr, ADDR);
                    if (!icb_cmd_read) begin
                        check("write_in_range", wr_seen < N_WR, 1);
                        if (wr_seen < N_WR) check("cmd_wdata", icb_cmd_wdata, src_words[wr_seen]);
                        pend_read = 0; pend_idx = wr_seen;
                        pend_err  = (wr_seen == err_wr_idx);
                        pend_data = pend_err ? err_val : 32'h0;
                        wr_seen++;
                    end else begin
                        pend_read = 1; pend_idx = rd_seen;
                        pend_err  = (rd_seen == err_rd_idx);
                        pend_data = pend_err ? err_val : rd_base + rd_seen;
                        rd_seen++;
                    end
                    pending = 1;
                end else if (icb_rsp_valid && icb_rsp_ready) begin
                    pending = 0;
                end
                prev_cmd_wait = icb_cmd_valid && !icb_cmd_ready;
                prev_addr = icb_cmd_addr; prev_read = icb_cmd_read; prev_wdata = icb_cmd_wdata;
                if (src_hs_last) src_idx++;
                if (prev_dst_wait) begin
                    check("dst_valid_held", dst_valid, 1);
                    check("dst_data_stable", dst_data, prev_dst);
                end
                if (dst_valid && dst_ready) begin
                    check("dst_data", dst_data, rd_base + dst_seen);
                    dst_seen++;
                end
                prev_dst_wait = dst_valid && !dst_ready;
                prev_dst = dst_data;
            end
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_err_code"}, err_code, 0);
        check({tag, "_src_ready"}, src_ready, 0);
        check({tag, "_cmd_valid"}, icb_cmd_valid, 0);
        check({tag, "_rsp_ready"}, icb_rsp_ready, 0);
        check({tag, "_dst_valid"}, dst_valid, 0);
        check({tag, "_dst_data"}, dst_data, 0);
    endtask

    task automatic setup(input vec_t v);
        stall_pct = v.stall; err_wr_idx = v.err_wr; err_rd_idx = v.err_rd;
        err_val = v.err_val; rd_base = v.rd_base;
        for (int i = 0; i < N_WR; i++) src_words[i] = v.src_rand != 0 ? $urandom : i;
        src_idx = 0; wr_seen = 0; rd_seen = 0; dst_seen = 0;
    endtask

    // Run one frame and compare the outcome with what the frame rules predict
    task automatic run_frame(input vec_t v, input int budget);
        int ncyc, exp_w, exp_r, exp_d;
        setup(v);
        start = 1; ncyc = 1;
        step(); ncyc++; start = 0;
        check("busy_after_start", busy, 1);
        check("err_cleared_on_start", err, 0);
        check("err_code_cleared_on_start", err_code, 0);
        while (!done && ncyc < budget) begin
            start = (ncyc == v.restart_at);
            step(); ncyc++;
        end
        start = 0;
        check("done_seen", done, 1);
        check("busy_low_at_done", busy, 0);
        if (v.lat > 0) check("frame_cycles", ncyc, v.lat);
        if (mute_rd0) begin
            exp_w = N_WR; exp_r = 1; exp_d = 0;
        end else if (v.err_wr >= 0) begin
            exp_w = v.err_wr + 1; exp_r = 0; exp_d = 0;
        end else begin
            exp_w = N_WR;
            exp_r = v.err_rd >= 0 ? v.err_rd + 1 : N_RD;
            exp_d = v.err_rd >= 0 ? v.err_rd : N_RD;
        end
        check("writes_issued", wr_seen, exp_w);
        check("reads_issued", rd_seen, exp_r);
        check("dst_words", dst_seen, exp_d);
        check("err_at_done", err, v.exp_err);
        check("err_code_at_done", err_code, v.exp_code);
        step();
        check("done_one_cycle", done, 0);
        check("idle_after_done", busy, 0);
        check("err_sticky", err, v.exp_err);
    endtask

    initial begin
        vec_t vecs [8];
        vec_t nom;
        int   guard;
        vecs[0] = '{0,  -1, -1, 32'h0,         32'hA0,    0, 50,  192, 1'b0, 32'h0};
        vecs[1] = '{0,   5, -1, 32'hF1F0_F001, 32'hA0,    0, 0,   15,  1'b1, 32'hF1F0_F001};
        vecs[2] = '{0,  -1,  3, 32'hF1F0_E971, 32'hA0,    0, 0,   174, 1'b1, 32'hF1F0_E971};
        vecs[3] = '{0,  -1, -1, 32'h0,         32'h100,   1, 0,   192, 1'b0, 32'h0};
        vecs[4] = '{40, -1, -1, 32'h0,         $urandom,  1, 0,   -1,  1'b0, 32'h0};
        vecs[5] = '{30, 77, -1, 32'h0BAD_0077, $urandom,  1, 0,   -1,  1'b1, 32'h0BAD_0077};
        vecs[6] = '{50, -1, -1, 32'h0,         $urandom,  1, 100, -1,  1'b0, 32'h0};
        vecs[7] = '{25, -1,  9, 32'hE0E0_0009, $urandom,  1, 0,   -1,  1'b1, 32'hE0E0_0009};
        nom     = '{20, -1, -1, 32'h0,         32'h5000,  1, 0,   -1,  1'b0, 32'h0};

        rst_n = 0; start = 0;
        repeat (3) step();
        check_reset("reset");
        rst_n = 1;
        step();

        for (int i = 0; i < 8; i++) run_frame(vecs[i], BUDGET);

        // reset while idle after an aborted frame
        check("err_before_idle_reset", err, 1);
        rst_n = 0;
        step();
        check_reset("idle_reset");
        rst_n = 1;
        step();

        // reset mid-write at word 40, then a clean frame
        setup(vecs[0]);
        start = 1;
        step();
        start = 0;
        guard = 0;
        while (wr_seen < 40 && guard < 500) begin
            step(); guard++;
        end
        check("reached_word_40", wr_seen >= 40, 1);
        rst_n = 0;
        step();
        check_reset("midframe_reset");
        step();
        rst_n = 1;
        step();
        run_frame(nom, BUDGET);

`ifdef ICB_MST_TIMEOUT_EN
        nom.stall = 0; nom.exp_err = 1'b1; nom.exp_code = 32'hDEAD_0001;
        mute_rd0 = 1;
        run_frame(nom, 70000);
        mute_rd0 = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
